addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters sharing one 8-bit add/sub datapath; legal values are 2..8.
REQ-002 The block SHALL derive IW = max(1, clog2(N)) as the requester-ID width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, N, where bit i means requester i presents an operation.
REQ-006 The block SHALL have port req_a, input, 8*N, carrying operand A of requester i in bits [8i+7:8i].
REQ-007 The block SHALL have port req_b, input, 8*N, carrying operand B of requester i in bits [8i+7:8i].
REQ-008 The block SHALL have port req_sub, input, N, where bit i = 1 selects A-B and 0 selects A+B for requester i.
REQ-009 The block SHALL have port req_ready, output, N, where bit i means requester i's operation is accepted this cycle.
REQ-010 The block SHALL have port rsp_valid, output, 1, meaning the response register holds a result.
REQ-011 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 The block SHALL have port rsp_id, output, IW, giving the index of the requester that owns the result.
REQ-013 The block SHALL have port rsp_s, output, 8, giving the 8-bit sum or difference.
REQ-014 The block SHALL have port rsp_cout, output, 1, giving the carry out of bit 7; for subtract it is 1 when there is no borrow (A >= B unsigned).
REQ-015 The block SHALL have port rsp_ovf, output, 1, giving the two's-complement signed overflow.

Function
REQ-016 The block SHALL contain exactly one 8-bit add/sub datapath computing S = A + (B XOR {8{sub}}) + sub and cout = carry out of bit 7.
REQ-017 The block SHALL compute ovf = (A[7] == Bx[7]) && (S[7] != A[7]), where Bx = B XOR {8{sub}}.
REQ-018 The block SHALL define load = !rsp_valid || rsp_ready; the response register may take new data only when load = 1.
REQ-019 When load = 1 and req_valid != 0, the block SHALL grant requester g = the first i with req_valid[i] = 1, searching upward from pointer ptr modulo N.
REQ-020 The block SHALL drive req_ready[g] = 1 only for the granted g and only when load = 1; all other req_ready bits SHALL be 0; req_ready SHALL NOT depend on rsp_valid/rsp_ready other than through load.
REQ-021 On a grant, at the clock edge the block SHALL register rsp_s, rsp_cout and rsp_ovf from requester g's operands, set rsp_id = g and rsp_valid = 1, and set ptr = (g+1) mod N.
REQ-022 When load = 1 and req_valid = 0, at the edge the block SHALL set rsp_valid to 0 (or keep it 0) and SHALL hold ptr.
REQ-023 When rsp_valid = 1 and rsp_ready = 0, the block SHALL hold rsp_s, rsp_cout, rsp_ovf, rsp_id and ptr stable, and drive all req_ready bits to 0.
REQ-024 Latency SHALL be 1 cycle from acceptance to rsp_valid; throughput SHALL be one operation per cycle while rsp_ready = 1 (pop and push in the same cycle allowed).
REQ-025 A requester whose req_valid drops before it is granted SHALL lose no state; the pointer SHALL advance only on a grant.
REQ-026 Fairness: with all N requesters continuously valid and rsp_ready = 1, each requester SHALL be granted exactly once in every N consecutive grants.
REQ-027 Arithmetic SHALL wrap modulo 256; no saturation.

Reset
REQ-028 Reset assertion SHALL immediately, without waiting for clk, force rsp_valid = 0, rsp_s = 0, rsp_id = 0, rsp_cout = 0, rsp_ovf = 0 and ptr = 0.
REQ-029 While reset = 1, req_ready SHALL be all 0; an in-flight result SHALL be discarded.
REQ-030 The first grant after reset deassertion SHALL search from requester 0.

Verification
REQ-031 Single add: only req 1 valid with A=0x05, B=0x03, sub=0 -> next cycle rsp_id=1, rsp_s=0x08, rsp_cout=0, rsp_ovf=0.
REQ-032 Boundary add: A=0xFF, B=0x01 -> rsp_s=0x00, rsp_cout=1, rsp_ovf=0; then A=0x7F, B=0x01 -> rsp_s=0x80, rsp_cout=0, rsp_ovf=1.
REQ-033 Subtract: A=0x03, B=0x05, sub=1 -> rsp_s=0xFE, rsp_cout=0, rsp_ovf=0; then A=0x80, B=0x01, sub=1 -> rsp_s=0x7F, rsp_cout=1, rsp_ovf=1.
REQ-034 Round robin: N=4, all req_valid held at 1, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, each req_ready a one-hot pulse.
REQ-035 Backpressure: result valid, rsp_ready=0 for 3 cycles with reqs 2 and 3 valid -> rsp_* stable and req_ready=0 throughout; after rsp_ready=1 -> req 2 (ptr) is granted in that same cycle.
REQ-036 Reset mid-stream: assert reset between edges while rsp_valid=1 and ptr=2 -> rsp_valid=0 at once; after release with all valid -> first rsp_id=0.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 8-bit add/sub datapath among N requesters; 1-cycle latency to rsp.
// A held response (rsp_valid && !rsp_ready) blocks all grants until the consumer takes it.
module addsub_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  input  logic [N-1:0]     req_sub,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [7:0]       rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    s;
    logic          cout;
    logic          ovf;
  } rsp_t;

  rsp_t          rsp_q;
  rsp_t          rsp_d;
  logic          rsp_valid_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          gnt_found;
  logic          load;
  logic [7:0]    a_sel;
  logic [7:0]    b_sel;
  logic          sub_sel;
  logic [7:0]    bx;
  logic [8:0]    sum9;

  assign load = !rsp_valid_q || rsp_ready;

  // Search upward from ptr, wrapping at N; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ptr_q) + k >= N)
        cand = IW'(int'(ptr_q) + k - N);
      else
        cand = IW'(int'(ptr_q) + k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == IW'(i)) begin
        a_sel   = req_a[8*i +: 8];
        b_sel   = req_b[8*i +: 8];
        sub_sel = req_sub[i];
      end
    end
  end

  // Single shared datapath: subtraction is A + ~B + 1.
  assign bx   = b_sel ^ {8{sub_sel}};
  assign sum9 = {1'b0, a_sel} + {1'b0, bx} + {8'd0, sub_sel};

  always_comb begin
    rsp_d.id   = gnt_idx;
    rsp_d.s    = sum9[7:0];
    rsp_d.cout = sum9[8];
    rsp_d.ovf  = (a_sel[7] == bx[7]) && (sum9[7] != a_sel[7]);
  end

  assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

  always_comb begin
    req_ready = '0;
    if (load && gnt_found && !reset)
      req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (gnt_found) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= rsp_d;
        ptr_q       <= ptr_nxt;
      end else begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_s     = rsp_q.s;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_ovf   = rsp_q.ovf;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter (N=4): directed scenarios plus randomized traffic vs. a behavioural model.
module tb_addsub_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0] req_sub = '0;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_s;
  logic         rsp_cout;
  logic         rsp_ovf;

  int checks = 0;
  int passed = 0;

  // Model state: what the response register should hold and where the search starts.
  bit       m_vld = 0;
  int       m_ptr = 0;
  int       m_id = 0;
  int       m_s = 0;
  bit       m_cout = 0;
  bit       m_ovf = 0;
  int       e_g = -1;
  logic [3:0] e_ready = '0;

  addsub_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // Integer arithmetic reference: unsigned result mod 256, borrow/carry and signed range.
  function automatic void arith(input int a, input int b, input bit sub,
                                output int s, output bit cout, output bit ovf);
    int r, sa, sb, sr;
    r    = sub ? a - b : a + b;
    s    = r & 255;
    cout = sub ? (a >= b) : (r > 255);
    sa   = (a >= 128) ? a - 256 : a;
    sb   = (b >= 128) ? b - 256 : b;
    sr   = sub ? sa - sb : sa + sb;
    ovf  = (sr > 127) || (sr < -128);
  endfunction

  task automatic set_req(input int i, input int a, input int b, input bit sub);
    req_a[8*i +: 8] = 8'(a);
    req_b[8*i +: 8] = 8'(b);
    req_sub[i]      = sub;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endtask

  task automatic predict();
    bit ld;
    ld = !m_vld || rsp_ready;
    e_g = -1;
    if (ld && !reset)
      for (int k = 0; k < N; k++)
        if (e_g < 0 && req_valid[(m_ptr + k) % N]) e_g = (m_ptr + k) % N;
    e_ready = (e_g >= 0) ? 4'(1 << e_g) : 4'd0;
  endtask

  task automatic advance();
    if (!m_vld || rsp_ready) begin
      if (e_g >= 0) begin
        arith(int'(req_a[8*e_g +: 8]), int'(req_b[8*e_g +: 8]), req_sub[e_g], m_s, m_cout, m_ovf);
        m_vld = 1; m_id = e_g; m_ptr = (e_g + 1) % N;
      end else begin
        m_vld = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF; rsp_ready = 1'b1; rand_ops();
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", rsp_valid); else passed++;
    checks++; if (rsp_s !== 8'h00) $display("FAIL reset_s: got %h exp 00", rsp_s); else passed++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d exp 0", rsp_id); else passed++;
    checks++; if ({rsp_cout, rsp_ovf} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {rsp_cout, rsp_ovf}); else passed++;
    checks++; if (req_ready !== 4'h0) $display("FAIL reset_ready: got %b exp 0000", req_ready); else passed++;
    reset = 1'b0;
    m_vld = 0; m_ptr = 0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'hF; rsp_ready = 1'b1; rand_ops();
      #1; predict();
      checks++; if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d]: got %b exp %b", k, req_ready, 4'(1 << (k % 4))); else passed++;
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) $display("FAIL rr_id[%0d]: got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, (k - 1) % 4); else passed++;
        checks++; if (rsp_s !== 8'(m_s) || rsp_cout !== m_cout || rsp_ovf !== m_ovf) $display("FAIL rr_data[%0d]: got %h/%b/%b exp %h/%b/%b", k, rsp_s, rsp_cout, rsp_ovf, m_s, m_cout, m_ovf); else passed++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1100; rsp_ready = 1'b0; rand_ops();
      #1; predict();
      checks++; if (req_ready !== 4'h0) $display("FAIL bp_ready[%0d]: got %b exp 0000", c, req_ready); else passed++;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) $display("FAIL bp_hold_id[%0d]: got v=%b id=%0d exp v=1 id=1", c, rsp_valid, rsp_id); else passed++;
      checks++; if (rsp_s !== 8'(m_s) || rsp_cout !== m_cout || rsp_ovf !== m_ovf) $display("FAIL bp_hold_data[%0d]: got %h/%b/%b exp %h/%b/%b", c, rsp_s, rsp_cout, rsp_ovf, m_s, m_cout, m_ovf); else passed++;
      advance();
    end
    rsp_ready = 1'b1;
    #1; predict();
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_release_ready: got %b exp 0100", req_ready); else passed++;
    advance();
    req_valid = 4'h0;
    #1; predict();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_s !== 8'(m_s)) $display("FAIL bp_release_rsp: got v=%b id=%0d s=%h exp v=1 id=2 s=%h", rsp_valid, rsp_id, rsp_s, m_s); else passed++;
    advance();
  endtask

  task automatic test_single_add();
    req_valid = 4'b0010; rsp_ready = 1'b1; rand_ops(); set_req(1, 8'h05, 8'h03, 1'b0);
    #1; predict();
    checks++; if (req_ready !== 4'b0010) $display("FAIL add_ready: got %b exp 0010", req_ready); else passed++;
    advance();
    req_valid = 4'h0;
    #1; predict();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) $display("FAIL add_id: got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); else passed++;
    checks++; if (rsp_s !== 8'h08 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) $display("FAIL add_data: got %h/%b/%b exp 08/0/0", rsp_s, rsp_cout, rsp_ovf); else passed++;
    advance();
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL add_drain: got %b exp 0", rsp_valid); else passed++;
    #1; advance_idle();
  endtask

  task automatic advance_idle();
    predict(); advance();
  endtask

  // Two back-to-back operations from one requester; pop and push overlap.
  task automatic test_pair(input string name, input int r, input int a0, input int b0, input int a1,
                           input int b1, input bit sub, input int s0, input bit c0, input bit o0,
                           input int s1, input bit c1, input bit o1);
    req_valid = 4'(1 << r); rsp_ready = 1'b1; rand_ops(); set_req(r, a0, b0, sub);
    #1; predict();
    checks++; if (req_ready !== 4'(1 << r)) $display("FAIL %s_ready0: got %b exp %b", name, req_ready, 4'(1 << r)); else passed++;
    advance();
    set_req(r, a1, b1, sub);
    #1; predict();
    checks++; if (rsp_s !== 8'(s0) || rsp_cout !== c0 || rsp_ovf !== o0) $display("FAIL %s_first: got %h/%b/%b exp %h/%b/%b", name, rsp_s, rsp_cout, rsp_ovf, s0, c0, o0); else passed++;
    checks++; if (req_ready !== 4'(1 << r)) $display("FAIL %s_ready1: got %b exp %b", name, req_ready, 4'(1 << r)); else passed++;
    advance();
    req_valid = 4'h0;
    #1; predict();
    checks++; if (rsp_s !== 8'(s1) || rsp_cout !== c1 || rsp_ovf !== o1 || rsp_id !== 2'(r)) $display("FAIL %s_second: got %h/%b/%b id=%0d exp %h/%b/%b id=%0d", name, rsp_s, rsp_cout, rsp_ovf, rsp_id, s1, c1, o1, r); else passed++;
    advance();
  endtask

  task automatic test_reset_midstream();
    req_valid = 4'b0010; rsp_ready = 1'b1; rand_ops();
    #1; predict(); advance();
    checks++; if (rsp_valid !== 1'b1 || m_ptr != 2) $display("FAIL mid_setup: got v=%b ptr=%0d exp v=1 ptr=2", rsp_valid, m_ptr); else passed++;
    req_valid = 4'hF;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_s !== 8'h00 || rsp_id !== 2'd0) $display("FAIL mid_async: got v=%b s=%h id=%0d exp v=0 s=00 id=0", rsp_valid, rsp_s, rsp_id); else passed++;
    checks++; if (req_ready !== 4'h0) $display("FAIL mid_ready: got %b exp 0000", req_ready); else passed++;
    m_vld = 0; m_ptr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1; predict();
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_ready: got %b exp 0001", req_ready); else passed++;
    advance();
    req_valid = 4'h0;
    #1; predict();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) $display("FAIL mid_first_id: got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id); else passed++;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1; predict();
      checks++; if (req_ready !== e_ready) $display("FAIL rnd_ready[%0d]: got %b exp %b", c, req_ready, e_ready); else passed++;
      checks++; if (rsp_valid !== m_vld) $display("FAIL rnd_valid[%0d]: got %b exp %b", c, rsp_valid, m_vld); else passed++;
      if (m_vld) begin
        checks++;
        if (rsp_id !== 2'(m_id) || rsp_s !== 8'(m_s) || rsp_cout !== m_cout || rsp_ovf !== m_ovf)
          $display("FAIL rnd_rsp[%0d]: got id=%0d %h/%b/%b exp id=%0d %h/%b/%b", c, rsp_id, rsp_s, rsp_cout, rsp_ovf, m_id, m_s, m_cout, m_ovf);
        else passed++;
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_add();
    test_pair("bnd_add", 0, 8'hFF, 8'h01, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    test_pair("sub", 3, 8'h03, 8'h05, 8'h80, 8'h01, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
